// File: rtl/axistream_egress_buffer_pkg.sv
// Shared types and elaboration helpers for the egress buffer slice.
package axistream_egress_buffer_pkg;

    // Write-side packet state: storing the current packet, or skipping the
    // remainder of a packet that already overflowed.
    typedef enum logic {
        ST_ACCEPT  = 1'b0,
        ST_DISCARD = 1'b1
    } wr_state_e;

    // Ceiling log2 for deriving address widths from depths.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // One byte-enable bit per TDATA byte.
    function automatic int unsigned keep_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axistream_egress_buffer_if.sv
// AXI Stream beat bundle with master (source) and slave (sink) views.
interface axistream_egress_buffer_if #(
    parameter int unsigned DW = 64
);
    localparam int unsigned KW = DW / 8;

    logic [DW-1:0] TDATA;
    logic [KW-1:0] TKEEP;
    logic          TLAST;
    logic          TVALID;
    logic          TREADY;

    modport master (
        output TDATA,
        output TKEEP,
        output TLAST,
        output TVALID,
        input  TREADY
    );

    modport slave (
        input  TDATA,
        input  TKEEP,
        input  TLAST,
        input  TVALID,
        output TREADY
    );

endinterface

// File: rtl/axistream_egress_buffer_egress_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Read data holds its value on cycles without a read enable.
module egress_sdp_ram #(
    parameter int unsigned WIDTH = 73,
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = 9
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port and registered read port, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/axistream_egress_buffer.sv
// Store-and-forward egress packet FIFO. Packets become visible to the read
// side only once their TLAST beat is stored; a packet that overflows is
// rewound out of the buffer and counted, so the input never backpressures.
module axistream_egress_buffer
    import axistream_egress_buffer_pkg::*;
#(
    parameter int unsigned SN_FWD_DATA_WIDTH = 64,
    parameter int unsigned DEPTH             = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    axistream_egress_buffer_if.slave   in_if,
    axistream_egress_buffer_if.master  out_if,
    output logic [15:0]                pkts_dropped,
    output logic [15:0]                pkts_buffered
);

    localparam int unsigned DW = SN_FWD_DATA_WIDTH;
    localparam int unsigned KW = keep_width(DW);
    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned WW = DW + KW + 1;
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
    localparam logic [AW:0] PTR_DEPTH = (AW + 1)'(DEPTH);

    wr_state_e      state_q;
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    wr_commit_q;
    logic [AW:0]    rd_ptr_q;
    logic [15:0]    drop_cnt_q;
    logic [15:0]    buf_cnt_q;

    logic           rd_pend_q;
    logic [1:0]     skid_cnt_q, skid_cnt_d;
    logic [WW-1:0]  skid0_q, skid0_d;
    logic [WW-1:0]  skid1_q, skid1_d;

    logic           accept;
    logic           full;
    logic           wr_en;
    logic           commit;
    logic           rd_en;
    logic           pop;
    logic           out_last_hs;
    logic [AW:0]    used;
    logic [2:0]     occ_next;
    logic [WW-1:0]  wr_word;
    logic [WW-1:0]  rd_word;
    logic [WW-1:0]  head;

    // ---------------- write side ----------------
    assign in_if.TREADY = ~rst;
    assign accept       = in_if.TVALID & in_if.TREADY;
    assign used         = wr_ptr_q - rd_ptr_q;
    assign full         = (used == PTR_DEPTH);
    assign wr_en        = accept & (state_q == ST_ACCEPT) & ~full;
    assign commit       = wr_en & in_if.TLAST;
    assign wr_word      = {in_if.TLAST, in_if.TKEEP, in_if.TDATA};

    // Write FSM: store beats, publish on TLAST, rewind and count on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCEPT;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            drop_cnt_q  <= '0;
        end else if (accept) begin
            case (state_q)
                ST_ACCEPT: begin
                    if (!full) begin
                        wr_ptr_q <= wr_ptr_q + PTR_ONE;
                        if (in_if.TLAST) begin
                            wr_commit_q <= wr_ptr_q + PTR_ONE;
                        end
                    end else begin
                        wr_ptr_q   <= wr_commit_q;
                        drop_cnt_q <= drop_cnt_q + 16'd1;
                        if (!in_if.TLAST) begin
                            state_q <= ST_DISCARD;
                        end
                    end
                end
                default: begin
                    if (in_if.TLAST) begin
                        state_q <= ST_ACCEPT;
                    end
                end
            endcase
        end
    end

    egress_sdp_ram #(
        .WIDTH (WW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (wr_word),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_word)
    );

    // ---------------- read side ----------------
    // The RAM output register acts as a bypass stage in front of the 2-entry
    // skid: a beat leaves straight from it when the skid is empty, and is
    // parked in the skid otherwise. Counting this cycle's pop in the
    // occupancy test is what allows one read per cycle under out_TREADY=1.
    assign pop         = out_if.TVALID & out_if.TREADY;
    assign out_last_hs = pop & out_if.TLAST;
    assign occ_next    = {1'b0, skid_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign rd_en       = (rd_ptr_q != wr_commit_q) && (occ_next < 3'd2);

    // Select the oldest pending beat for the output; zero when idle.
    always_comb begin
        head = '0;
        if (skid_cnt_q != 2'd0) begin
            head = skid0_q;
        end else if (rd_pend_q) begin
            head = rd_word;
        end
    end

    assign out_if.TVALID = (skid_cnt_q != 2'd0) | rd_pend_q;
    assign out_if.TLAST  = head[WW-1];
    assign out_if.TKEEP  = head[DW +: KW];
    assign out_if.TDATA  = head[DW-1:0];

    // Skid next-state: absorb RAM data that could not leave, shift on pop.
    always_comb begin
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        skid_cnt_d = skid_cnt_q;
        case (skid_cnt_q)
            2'd0: begin
                if (rd_pend_q && !pop) begin
                    skid0_d    = rd_word;
                    skid_cnt_d = 2'd1;
                end
            end
            2'd1: begin
                if (pop && rd_pend_q) begin
                    skid0_d = rd_word;
                end else if (pop) begin
                    skid_cnt_d = 2'd0;
                end else if (rd_pend_q) begin
                    skid1_d    = rd_word;
                    skid_cnt_d = 2'd2;
                end
            end
            default: begin
                if (pop) begin
                    skid0_d = skid1_q;
                    if (rd_pend_q) begin
                        skid1_d = rd_word;
                    end else begin
                        skid_cnt_d = 2'd1;
                    end
                end
            end
        endcase
    end

    // Read pointer, in-flight flag and skid storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            rd_pend_q  <= 1'b0;
            skid_cnt_q <= 2'd0;
            skid0_q    <= '0;
            skid1_q    <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            rd_pend_q  <= rd_en;
            skid_cnt_q <= skid_cnt_d;
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
        end
    end

    // Committed-but-unsent packet count.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_cnt_q <= '0;
        end else begin
            case ({commit, out_last_hs})
                2'b10:   buf_cnt_q <= buf_cnt_q + 16'd1;
                2'b01:   buf_cnt_q <= buf_cnt_q - 16'd1;
                default: buf_cnt_q <= buf_cnt_q;
            endcase
        end
    end

    assign pkts_dropped  = drop_cnt_q;
    assign pkts_buffered = buf_cnt_q;

endmodule

// File: tb/tb_axistream_egress_buffer.sv
// Directed bench for axistream_egress_buffer (DW=64, DEPTH=16).
module tb_axistream_egress_buffer;

    typedef struct packed {
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pkts_dropped;
    logic [15:0] pkts_buffered;

    axistream_egress_buffer_if #(.DW(64)) in_bus ();
    axistream_egress_buffer_if #(.DW(64)) out_bus ();

    axistream_egress_buffer #(
        .SN_FWD_DATA_WIDTH (64),
        .DEPTH             (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_if         (in_bus),
        .out_if        (out_bus),
        .pkts_dropped  (pkts_dropped),
        .pkts_buffered (pkts_buffered)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    beat_t exp_q[$];
    beat_t got_q[$];
    int    got_cyc[$];
    int    stall_cnt = 0;
    int    stall_err = 0;
    int    in_rdy_low = 0;
    bit    prev_stall = 1'b0;
    logic [73:0] prev_out;

    // Cycle index, advanced on every active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records handshakes and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (!in_bus.TREADY) in_rdy_low++;
            if (prev_stall) begin
                stall_cnt++;
                if ({out_bus.TVALID, out_bus.TLAST, out_bus.TKEEP, out_bus.TDATA} !== prev_out)
                    stall_err++;
            end
            if (out_bus.TVALID && out_bus.TREADY) begin
                got_q.push_back({out_bus.TLAST, out_bus.TKEEP, out_bus.TDATA});
                got_cyc.push_back(cyc);
            end
            prev_stall = out_bus.TVALID && !out_bus.TREADY;
            prev_out   = {out_bus.TVALID, out_bus.TLAST, out_bus.TKEEP, out_bus.TDATA};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    // Drive one packet, one beat per cycle; entered and left at posedge+1.
    task automatic send_pkt(input int id, input int n, input logic [7:0] lk,
                            input bit sb, output int last_cyc);
        last_cyc = -1;
        for (int b = 0; b < n; b++) begin
            in_bus.TVALID = 1'b1;
            in_bus.TDATA  = (64'(id) << 32) | 64'(b);
            in_bus.TKEEP  = (b == n - 1) ? lk : 8'hFF;
            in_bus.TLAST  = (b == n - 1);
            if (sb) exp_q.push_back({in_bus.TLAST, in_bus.TKEEP, in_bus.TDATA});
            if (b == n - 1) last_cyc = cyc;
            @(posedge clk); #1;
        end
    endtask

    // Bounded wait for n output beats plus a few idle cycles.
    task automatic wait_beats(input int n);
        for (int c = 0; c < 200 && got_q.size() < n; c++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_bus.TVALID = 1'b0; in_bus.TDATA = '0; in_bus.TKEEP = '0; in_bus.TLAST = 1'b0;
        out_bus.TREADY = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_bus.TREADY !== 1'b0) begin errors++; $display("FAIL rst_in_tready got=%b exp=0", in_bus.TREADY); end
        checks++; if (out_bus.TVALID !== 1'b0) begin errors++; $display("FAIL rst_out_tvalid got=%b exp=0", out_bus.TVALID); end
        checks++; if ({out_bus.TLAST, out_bus.TKEEP, out_bus.TDATA} !== 73'd0) begin errors++; $display("FAIL rst_out_data got=%h exp=0", out_bus.TDATA); end
        checks++; if (pkts_dropped !== 16'd0 || pkts_buffered !== 16'd0) begin errors++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", pkts_dropped, pkts_buffered); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_bus.TREADY !== 1'b1) begin errors++; $display("FAIL post_rst_in_tready got=%b exp=1", in_bus.TREADY); end
    endtask

    task automatic test_single();
        int lc;
        clear_q();
        send_pkt(1, 3, 8'h0F, 1'b1, lc);
        in_bus.TVALID = 1'b0;
        @(negedge clk);
        checks++; if (pkts_buffered !== 16'd1) begin errors++; $display("FAIL single_buffered1 got=%0d exp=1", pkts_buffered); end
        wait_beats(3);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (got_cyc.size() == 0 || got_cyc[0] !== lc + 2) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", (got_cyc.size() == 0) ? -1 : got_cyc[0], lc + 2); end
        checks++; if (pkts_buffered !== 16'd0) begin errors++; $display("FAIL single_buffered0 got=%0d exp=0", pkts_buffered); end
    endtask

    task automatic test_back_to_back();
        int lc;
        clear_q();
        stall_cnt = 0;
        stall_err = 0;
        fork
            begin
                send_pkt(2, 4, 8'h3F, 1'b1, lc);
                send_pkt(3, 5, 8'h01, 1'b1, lc);
                in_bus.TVALID = 1'b0;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_bus.TREADY = (c % 2 == 0);
                    @(posedge clk); #1;
                end
                out_bus.TREADY = 1'b1;
            end
        join
        wait_beats(9);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (stall_err !== 0) begin errors++; $display("FAIL b2b_stable got=%0d unstable stalls exp=0", stall_err); end
        checks++; if (!(stall_cnt > 0)) begin errors++; $display("FAIL b2b_stalls_seen got=%0d exp>0", stall_cnt); end
    endtask

    task automatic test_overflow_drop();
        int lc;
        clear_q();
        stall_err = 0;
        out_bus.TREADY = 1'b0;
        send_pkt(4, 10, 8'hFF, 1'b1, lc);
        send_pkt(5, 10, 8'h07, 1'b0, lc);
        in_bus.TVALID = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (pkts_dropped !== 16'd1) begin errors++; $display("FAIL ovf_dropped got=%0d exp=1", pkts_dropped); end
        checks++; if (pkts_buffered !== 16'd1) begin errors++; $display("FAIL ovf_buffered got=%0d exp=1", pkts_buffered); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ovf_no_output got=%0d exp=0", got_q.size()); end
        out_bus.TREADY = 1'b1;
        wait_beats(10);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (stall_err !== 0) begin errors++; $display("FAIL ovf_stable got=%0d exp=0", stall_err); end
    endtask

    task automatic test_long_drop();
        int lc;
        clear_q();
        in_rdy_low = 0;
        send_pkt(6, 20, 8'hFF, 1'b0, lc);
        send_pkt(7, 2, 8'h1F, 1'b1, lc);
        in_bus.TVALID = 1'b0;
        wait_beats(2);
        checks++; if (pkts_dropped !== 16'd2) begin errors++; $display("FAIL long_dropped got=%0d exp=2", pkts_dropped); end
        checks++; if (in_rdy_low !== 0) begin errors++; $display("FAIL long_in_tready_low got=%0d cycles exp=0", in_rdy_low); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL long_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL long_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_exact_depth();
        int lc;
        clear_q();
        send_pkt(8, 16, 8'h03, 1'b1, lc);
        in_bus.TVALID = 1'b0;
        wait_beats(16);
        checks++; if (pkts_dropped !== 16'd2) begin errors++; $display("FAIL depth_dropped got=%0d exp=2", pkts_dropped); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL depth_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL depth_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_packet();
        int lc;
        clear_q();
        out_bus.TREADY = 1'b0;
        send_pkt(9, 3, 8'hFF, 1'b0, lc);
        in_bus.TVALID = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int b = 0; b < 2; b++) begin
            in_bus.TVALID = 1'b1;
            in_bus.TDATA  = (64'(10) << 32) | 64'(b);
            in_bus.TKEEP  = 8'hFF;
            in_bus.TLAST  = 1'b0;
            @(posedge clk); #1;
        end
        in_bus.TVALID = 1'b0;
        checks++; if (out_bus.TVALID !== 1'b1 || pkts_buffered !== 16'd1) begin errors++; $display("FAIL prerst_pending got=%b/%0d exp=1/1", out_bus.TVALID, pkts_buffered); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_bus.TVALID !== 1'b0) begin errors++; $display("FAIL midrst_out_tvalid got=%b exp=0", out_bus.TVALID); end
        checks++; if (out_bus.TDATA !== 64'd0) begin errors++; $display("FAIL midrst_out_tdata got=%h exp=0", out_bus.TDATA); end
        checks++; if (pkts_dropped !== 16'd0 || pkts_buffered !== 16'd0) begin errors++; $display("FAIL midrst_counters got=%0d/%0d exp=0/0", pkts_dropped, pkts_buffered); end
        rst = 1'b0;
        out_bus.TREADY = 1'b1;
        @(posedge clk); #1;
        clear_q();
        send_pkt(11, 3, 8'h7F, 1'b1, lc);
        in_bus.TVALID = 1'b0;
        wait_beats(3);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_streaming();
        int lc;
        int lc_first;
        clear_q();
        out_bus.TREADY = 1'b1;
        send_pkt(12, 8, 8'hFF, 1'b1, lc_first);
        for (int p = 13; p < 16; p++) send_pkt(p, 8, 8'hFF, 1'b1, lc);
        in_bus.TVALID = 1'b0;
        wait_beats(32);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stream_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (got_cyc.size() == 0 || got_cyc[0] !== lc_first + 2) begin errors++; $display("FAIL stream_latency got=%0d exp=%0d", (got_cyc.size() == 0) ? -1 : got_cyc[0], lc_first + 2); end
        checks++; if (got_cyc.size() == 0 || (got_cyc[got_cyc.size() - 1] - got_cyc[0]) !== 31) begin errors++; $display("FAIL stream_rate got_span=%0d exp=31", (got_cyc.size() == 0) ? -1 : got_cyc[got_cyc.size() - 1] - got_cyc[0]); end
        checks++; if (pkts_dropped !== 16'd0) begin errors++; $display("FAIL stream_dropped got=%0d exp=0", pkts_dropped); end
        checks++; if (pkts_buffered !== 16'd0) begin errors++; $display("FAIL stream_buffered got=%0d exp=0", pkts_buffered); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow_drop();
        test_long_drop();
        test_exact_depth();
        test_reset_mid_packet();
        test_streaming();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
